// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Entry field widths bound INSTR_ADDR_WIDTH and INSTR_WIDTH.
package fetch_pkg;

   localparam int unsigned FETCH_AW = 32;
   localparam int unsigned FETCH_IW = 32;
   localparam logic [1:0] FETCH_ALIGN_MASK = 2'b11;

   typedef enum logic [0:0] {
      FETCH,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [FETCH_AW-1:0] addr;
      logic [FETCH_IW-1:0] data;
      logic                fault;
      logic                filled;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer: allocate at tail, fill oldest unfilled,
// pop at head, flush on redirect.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                alloc_en,
   input  fetch_entry_t        alloc_entry,
   input  logic                fill_en,
   input  logic [FETCH_IW-1:0] fill_data,
   input  logic                fill_fault,
   input  logic                pop_en,
   output fetch_entry_t        head,
   output logic                head_valid,
   output logic [CW-1:0]       occupancy,
   output logic [CW-1:0]       pending
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] occ_q, occ_d;
   logic [PW-1:0] fill_idx;
   logic          fill_hit;

   assign head       = mem_q[rd_ptr_q];
   assign head_valid = (occ_q != '0);
   assign occupancy  = occ_q;

   // Misaligned entries are born filled, so the scan skips them.
   always_comb begin
      fill_idx = rd_ptr_q;
      fill_hit = 1'b0;
      pending  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if ((CW'(i) < occ_q) &&
             !mem_q[rd_ptr_q + PW'(i)].filled) begin
            pending = pending + CW'(1);
            if (!fill_hit) begin
               fill_idx = rd_ptr_q + PW'(i);
               fill_hit = 1'b1;
            end
         end
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (alloc_en) begin
            mem_d[wr_ptr_q] = alloc_entry;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (fill_en && fill_hit) begin
            mem_d[fill_idx].data   = fill_fault ? '0 : fill_data;
            mem_d[fill_idx].fault  = fill_fault;
            mem_d[fill_idx].filled = 1'b1;
         end
         if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         occ_d = occ_q + CW'(alloc_en) - CW'(pop_en);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues PC addresses to instruction memory and
// hands ordered instructions to decode; drains on redirect.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned INSTR_ADDR_WIDTH = 32,
   parameter int unsigned INSTR_WIDTH      = 32,
   parameter int unsigned BUF_DEPTH        = 4
) (
   input  logic                        clk,
   input  logic                        async_rst_n,
   input  logic                        clk_en,
   input  logic                        pc_valid,
   input  logic [INSTR_ADDR_WIDTH-1:0] pc_addr,
   output logic                        pc_ready,
   input  logic                        redirect,
   output logic                        mem_req_valid,
   output logic [INSTR_ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                        mem_req_ready,
   input  logic                        mem_rsp_valid,
   input  logic [INSTR_WIDTH-1:0]      mem_rsp_data,
   input  logic                        mem_rsp_err,
   output logic                        instr_valid,
   output logic [INSTR_WIDTH-1:0]      instr_data,
   output logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
   output logic                        instr_fault,
   input  logic                        instr_ready
);

   localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

   fetch_state_e  state_q, state_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] occupancy, pending;
   fetch_entry_t  head, alloc_entry;
   logic          head_valid;
   logic          aligned, credit, fetching;
   logic          alloc_en, fill_en, pop_en, flush;

   assign aligned = ((pc_addr[1:0] & FETCH_ALIGN_MASK) == 2'b00);
   assign credit  = (occupancy < CW'(BUF_DEPTH));

   always_comb begin
      alloc_entry        = '0;
      alloc_entry.addr   = FETCH_AW'(pc_addr);
      alloc_entry.fault  = !aligned;
      alloc_entry.filled = !aligned;
   end

   always_ff @(posedge clk or negedge async_rst_n) begin
      if (!async_rst_n) begin
         state_q <= FETCH;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         drop_q  <= drop_d;
      end
   end

   // A response landing with the redirect is itself dropped.
   always_comb begin
      state_d = state_q;
      drop_d  = drop_q;
      if (clk_en) begin
         unique case (state_q)
            FETCH: begin
               if (redirect) begin
                  drop_d = (mem_rsp_valid && pending != '0)
                         ? pending - CW'(1) : pending;
               end
            end
            DRAIN: begin
               if (mem_rsp_valid && drop_q != '0) begin
                  drop_d = drop_q - CW'(1);
               end
            end
            default: ;
         endcase
         state_d = (drop_d != '0) ? DRAIN : FETCH;
      end
   end

   always_comb begin
      fetching      = clk_en && (state_q == FETCH) && !redirect;
      mem_req_valid = fetching && credit && pc_valid && aligned;
      pc_ready      = fetching && credit && pc_valid &&
                      (!aligned || mem_req_ready);
      mem_req_addr  = mem_req_valid ? pc_addr : '0;
      alloc_en      = pc_ready;
      fill_en       = fetching && mem_rsp_valid;
      flush         = clk_en && redirect;
      instr_valid   = clk_en && !redirect && head_valid && head.filled;
      pop_en        = instr_valid && instr_ready;
      instr_data    = instr_valid ? INSTR_WIDTH'(head.data) : '0;
      instr_addr    = instr_valid ? INSTR_ADDR_WIDTH'(head.addr) : '0;
      instr_fault   = instr_valid && head.fault;
   end

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk         (clk),
      .rst_n       (async_rst_n),
      .flush       (flush),
      .alloc_en    (alloc_en),
      .alloc_entry (alloc_entry),
      .fill_en     (fill_en),
      .fill_data   (FETCH_IW'(mem_rsp_data)),
      .fill_fault  (mem_rsp_err),
      .pop_en      (pop_en),
      .head        (head),
      .head_valid  (head_valid),
      .occupancy   (occupancy),
      .pending     (pending)
   );

endmodule
